fpga_proto_ram_model_sdp: RTL and testbench
===========================================

Name: fpga_proto_ram_model_sdp

Overview:
- Simple-dual-port (1 write, 1 read) block-RAM model for FPGA prototyping; next generation of the single-port model.
- Adds a lane write mask that is actually applied, configurable read latency and collision mode, and a hardware clear sequencer.
- Sits under CAM/lookup tables that need concurrent update and search plus deterministic post-reset contents.

Parameters:
- ADDR_WIDTH, 9, address width.
- RAM_DEPTH, 2**ADDR_WIDTH, words implemented; must be <= 2**ADDR_WIDTH.
- DATA_WIDTH, 72, word width.
- MASK_WIDTH, 9, lane count; LANE_WIDTH = DATA_WIDTH/MASK_WIDTH, must divide exactly (elaboration error otherwise).
- READ_LATENCY, 1, 1 or 2; 2 adds an output register. Other values are an elaboration error.
- COLL_MODE, "WRITE_FIRST", "WRITE_FIRST" or "READ_FIRST"; read data when rd_addr == wr_addr in the same cycle.
- INIT_ON_RESET, 1, 1: clear sweep after reset release; 0: no sweep, ready immediately.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_req  in  1  pulse: start a clear sweep (ignored while busy)
- init_busy  out  1  clear sweep in progress
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  MASK_WIDTH  per-lane write enable, active-high
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- rd_valid  out  1  rd_data valid, READ_LATENCY cycles after an accepted rd_en
- rd_data  out  DATA_WIDTH  read data
- rd_perr  out  MASK_WIDTH  per-lane parity error; present only with the optional feature

Behaviour:
- Reset values:
  - rd_valid=0, rd_data=0, rd_perr=0, sweep counter=0.
  - init_busy=1 if INIT_ON_RESET=1, else 0.
  - Array contents are not reset by rst_n.
- FSM states: RESET, CLEAR, RUN.
  - RESET → CLEAR on the first clk after rst_n rises, if INIT_ON_RESET=1; otherwise RESET → RUN.
  - CLEAR: writes zero to address cnt each cycle, cnt 0..RAM_DEPTH-1. After cnt=RAM_DEPTH-1 → RUN; init_busy drops the following cycle. Sweep takes exactly RAM_DEPTH cycles.
  - RUN: init_req=1 → CLEAR with cnt=0.
- While init_busy=1: wr_en and rd_en are ignored, no rd_valid is produced, and reads in flight from before the sweep still complete.
- Write (RUN, wr_en=1): for each lane i with wr_mask[i]=1, lane i of mem[wr_addr] takes wr_data lane i; lanes with mask 0 are unchanged. wr_mask=0 means no write.
- Read (RUN, rd_en=1):
  - READ_LATENCY=1: rd_data and rd_valid update on the next edge.
  - READ_LATENCY=2: one more register stage follows.
  - rd_data holds its last value when no read completes; rd_valid is a single-cycle pulse per read.
- Collision (rd_en & wr_en, same address):
  - WRITE_FIRST: masked lanes return wr_data; unmasked lanes return stored data.
  - READ_FIRST: all lanes return pre-write contents.
- Out of range (address >= RAM_DEPTH): the write is dropped; the read returns zero with rd_valid asserted.
- Back-to-back reads: one per cycle, full throughput, no stalls.
- rst_n asserted mid-sweep or mid-read: outputs return to reset values immediately (asynchronously); the sweep restarts from 0 after release.

Optional Feature:
- Macro: FPGA_PROTO_RAM_PARITY_EN.
- With the macro:
  - Each lane stores one extra even-parity bit, computed on write; the clear sweep writes parity 0.
  - On read, rd_perr[i]=1 when the stored parity mismatches the lane data; it follows rd_data timing and collision selection.
  - A test-only input perr_inject (MASK_WIDTH) inverts the written parity bits.
- Without the macro: the rd_perr and perr_inject ports and the parity storage do not exist.

Decomposition:
- Shared package fpga_proto_ram_pkg holds:
  - enum ram_coll_mode_e (COLL_WRITE_FIRST, COLL_READ_FIRST);
  - enum ram_init_state_e (RESET, CLEAR, RUN);
  - function lane_parity().
- Sub-module fpga_proto_ram_init_seq: the sweep counter/FSM. Outputs init_busy, clr_we, clr_addr; the top muxes these onto the write port.

Test Plan:
- Reset release, INIT_ON_RESET=1, RAM_DEPTH=512 → init_busy high for exactly 512 cycles; afterwards reading addr 0x1FF gives 0 with rd_valid one cycle after rd_en.
- Write 0xFF..FF to addr 5 with mask all ones, then write 0 with wr_mask=9'h001 → read addr 5 gives 72'hFF_FFFF_FFFF_FFFF_FF00.
- Same-cycle write 0xAA..AA (mask 9'h1FF) and read to addr 7, which holds 0x11..11 → WRITE_FIRST returns 0xAA..AA; READ_FIRST returns 0x11..11.
- READ_LATENCY=2: reads issued on cycles 10, 11, 12 → rd_valid on 12, 13, 14, data in order.
- init_req during RUN with a read issued the same cycle → that read is ignored; rd_valid stays low until the sweep completes; all addresses then read 0.
- FPGA_PROTO_RAM_PARITY_EN: write with perr_inject=9'h004 → read gives rd_perr=9'h004 with correct rd_data; rst_n pulsed mid-sweep → rd_valid=0 and init_busy=1 immediately.

Source files
------------

// File: rtl/fpga_proto_ram_model_sdp_pkg.sv
// -----------------------------------------------------------------------------
// fpga_proto_ram_pkg
// Shared types and helpers for the simple-dual-port prototyping RAM model.
//   ram_coll_mode_e  : read-during-write behaviour on an address collision
//   ram_init_state_e : states of the clear sequencer
//   lane_parity()    : even parity over one lane (zero-extended to LANE_MAX_WIDTH)
// Optional feature macro used by the files importing this package:
//   FPGA_PROTO_RAM_PARITY_EN
// -----------------------------------------------------------------------------
package fpga_proto_ram_pkg;

  typedef enum logic {
    COLL_WRITE_FIRST,
    COLL_READ_FIRST
  } ram_coll_mode_e;

  typedef enum logic [1:0] {
    RESET,
    CLEAR,
    RUN
  } ram_init_state_e;

  // Widest lane lane_parity() accepts; narrower lanes are zero-extended,
  // which does not change their parity.
  localparam int LANE_MAX_WIDTH = 64;

  function automatic logic lane_parity(input logic [LANE_MAX_WIDTH-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/fpga_proto_ram_model_sdp_if.sv
// -----------------------------------------------------------------------------
// fpga_proto_ram_model_sdp_if
// Write port + read port of the SDP RAM model.
//   master : drives wr_en/wr_addr/wr_data/wr_mask, rd_en/rd_addr
//            (and perr_inject), receives rd_valid/rd_data (and rd_perr)
//   slave  : the RAM side
// With FPGA_PROTO_RAM_PARITY_EN defined, perr_inject and rd_perr exist.
// -----------------------------------------------------------------------------
interface fpga_proto_ram_model_sdp_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 72,
  parameter int MASK_WIDTH = 9
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] wr_mask;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
`ifdef FPGA_PROTO_RAM_PARITY_EN
  logic [MASK_WIDTH-1:0] perr_inject;
  logic [MASK_WIDTH-1:0] rd_perr;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
`ifdef FPGA_PROTO_RAM_PARITY_EN
    output perr_inject,
    input  rd_perr,
`endif
    input  rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
`ifdef FPGA_PROTO_RAM_PARITY_EN
    input  perr_inject,
    output rd_perr,
`endif
    output rd_valid, rd_data
  );

endinterface

// File: rtl/fpga_proto_ram_model_sdp_init_seq.sv
// -----------------------------------------------------------------------------
// fpga_proto_ram_init_seq
// Clear sequencer: after reset release (INIT_ON_RESET=1) or on init_req in RUN
// it walks cnt = 0..RAM_DEPTH-1, one zero-write per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   init_req   : start a sweep (honoured only in RUN)
//   init_busy  : sweep pending or in progress (registered)
//   clr_we     : sweep write strobe this cycle
//   clr_addr   : sweep write address this cycle
// -----------------------------------------------------------------------------
module fpga_proto_ram_init_seq
  import fpga_proto_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 9,
  parameter int RAM_DEPTH     = 2**ADDR_WIDTH,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic                  BUSY_AT_RESET = (INIT_ON_RESET != 0);

  ram_init_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      RESET: begin
        cnt_d   = '0;
        state_d = BUSY_AT_RESET ? CLEAR : RUN;
        busy_d  = BUSY_AT_RESET;
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (init_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values;
  // blocking = would let later statements see already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
      cnt_q   <= '0;
      busy_q  <= BUSY_AT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign init_busy = busy_q;
  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = cnt_q;

endmodule

// File: rtl/fpga_proto_ram_model_sdp.sv
// -----------------------------------------------------------------------------
// fpga_proto_ram_model_sdp
// Simple-dual-port block-RAM model: one masked write port, one read port with
// READ_LATENCY 1 or 2, selectable collision mode and a hardware clear sweep.
//   clk, rst_n : clock, asynchronous active-low reset (contents not reset)
//   init_req   : start a clear sweep (ignored while busy)
//   init_busy  : clear sweep in progress; accesses are ignored meanwhile
//   bus        : fpga_proto_ram_model_sdp_if.slave (write + read ports)
// Optional: FPGA_PROTO_RAM_PARITY_EN adds one even-parity bit per lane,
// bus.perr_inject (flips written parity) and bus.rd_perr.
// -----------------------------------------------------------------------------
module fpga_proto_ram_model_sdp
  import fpga_proto_ram_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 9,
  parameter int    RAM_DEPTH     = 2**ADDR_WIDTH,
  parameter int    DATA_WIDTH    = 72,
  parameter int    MASK_WIDTH    = 9,
  parameter int    READ_LATENCY  = 1,
  parameter string COLL_MODE     = "WRITE_FIRST",
  parameter int    INIT_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_req,
  output logic                     init_busy,
  fpga_proto_ram_model_sdp_if.slave bus
);

  localparam int LANE_WIDTH = DATA_WIDTH / MASK_WIDTH;
  localparam int IDX_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam ram_coll_mode_e COLL_SEL =
    (COLL_MODE == "READ_FIRST") ? COLL_READ_FIRST : COLL_WRITE_FIRST;
`ifdef FPGA_PROTO_RAM_PARITY_EN
  localparam int PAY_W = DATA_WIDTH + MASK_WIDTH;
`else
  localparam int PAY_W = DATA_WIDTH;
`endif

  // Parameter legality is enforced at elaboration.
  if (MASK_WIDTH < 1 || (DATA_WIDTH % MASK_WIDTH) != 0) begin : g_bad_mask
    $fatal(1, "DATA_WIDTH must be an exact multiple of MASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  if (COLL_MODE != "WRITE_FIRST" && COLL_MODE != "READ_FIRST") begin : g_bad_coll
    $fatal(1, "COLL_MODE must be WRITE_FIRST or READ_FIRST");
  end
  if (RAM_DEPTH < 1 || RAM_DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $fatal(1, "RAM_DEPTH must be in 1..2**ADDR_WIDTH");
  end
`ifdef FPGA_PROTO_RAM_PARITY_EN
  if (LANE_WIDTH > LANE_MAX_WIDTH) begin : g_bad_lane
    $fatal(1, "LANE_WIDTH exceeds lane_parity() input width");
  end
`endif

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  fpga_proto_ram_init_seq #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RAM_DEPTH    (RAM_DEPTH),
    .INIT_ON_RESET(INIT_ON_RESET)
  ) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // ---------------------------------------------------------------------------
  // Access qualification. A read or write in the same cycle as an honoured
  // init_req is dropped too: the sweep is about to overwrite the array anyway.
  // ---------------------------------------------------------------------------
  logic             access_ok, wr_in_range, rd_in_range, wr_acc, rd_acc, coll_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign access_ok   = !init_busy && !init_req;
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_LIMIT);
  assign wr_acc      = bus.wr_en && access_ok && wr_in_range;
  assign rd_acc      = bus.rd_en && access_ok;
  assign wr_idx      = bus.wr_addr[IDX_W-1:0];
  assign rd_idx      = bus.rd_addr[IDX_W-1:0];
  assign coll_hit    = wr_acc && (bus.wr_addr == bus.rd_addr);

  // ---------------------------------------------------------------------------
  // Write port mux: sweep has priority (the two never overlap in practice)
  // ---------------------------------------------------------------------------
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [MASK_WIDTH-1:0] mem_mask;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = wr_acc;
    mem_idx   = wr_idx;
    mem_mask  = bus.wr_mask;
    mem_wdata = bus.wr_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_idx   = clr_addr[IDX_W-1:0];
      mem_mask  = '1;
      mem_wdata = '0;
    end
  end

  logic [DATA_WIDTH-1:0] mem_data [RAM_DEPTH];

`ifdef FPGA_PROTO_RAM_PARITY_EN
  logic [MASK_WIDTH-1:0] mem_par [RAM_DEPTH];
  logic [MASK_WIDTH-1:0] mem_wpar;

  // Sweep data is zero, so its parity is zero; injection applies only to
  // user writes.
  always_comb begin
    mem_wpar = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      mem_wpar[i] = lane_parity(LANE_MAX_WIDTH'(mem_wdata[i*LANE_WIDTH +: LANE_WIDTH]))
                    ^ (bus.perr_inject[i] & ~clr_we);
    end
  end
`endif

  // NOTE: the storage arrays have no reset; deterministic contents come from
  // the clear sweep, which keeps the array mappable to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (mem_mask[i]) begin
          mem_data[mem_idx][i*LANE_WIDTH +: LANE_WIDTH] <=
            mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef FPGA_PROTO_RAM_PARITY_EN
          mem_par[mem_idx][i] <= mem_wpar[i];
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read word: the array read sees pre-write contents (READ_FIRST for free);
  // WRITE_FIRST overlays only the lanes being written this cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;
  logic [PAY_W-1:0]      rd_pay;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_data[rd_idx];
      if (COLL_SEL == COLL_WRITE_FIRST && coll_hit) begin
        for (int i = 0; i < MASK_WIDTH; i++) begin
          if (bus.wr_mask[i]) begin
            rd_word[i*LANE_WIDTH +: LANE_WIDTH] = bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

`ifdef FPGA_PROTO_RAM_PARITY_EN
  logic [MASK_WIDTH-1:0] rd_perr_word;

  always_comb begin
    rd_perr_word = '0;
    if (rd_in_range) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (COLL_SEL == COLL_WRITE_FIRST && coll_hit && bus.wr_mask[i]) begin
          rd_perr_word[i] = mem_wpar[i]
            ^ lane_parity(LANE_MAX_WIDTH'(bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH]));
        end else begin
          rd_perr_word[i] = mem_par[rd_idx][i]
            ^ lane_parity(LANE_MAX_WIDTH'(mem_data[rd_idx][i*LANE_WIDTH +: LANE_WIDTH]));
        end
      end
    end
  end

  assign rd_pay = {rd_perr_word, rd_word};
`else
  assign rd_pay = rd_word;
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline: optional middle stage, then the output register which
  // holds its payload whenever no read completes.
  // ---------------------------------------------------------------------------
  logic             st_valid;
  logic [PAY_W-1:0] st_pay;

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s1_valid_q, s1_valid_d;
    logic [PAY_W-1:0] s1_pay_q, s1_pay_d;

    always_comb begin
      s1_valid_d = rd_acc;
      s1_pay_d   = rd_acc ? rd_pay : s1_pay_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_pay_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_pay_q   <= s1_pay_d;
      end
    end

    assign st_valid = s1_valid_q;
    assign st_pay   = s1_pay_q;
  end else begin : g_lat1
    assign st_valid = rd_acc;
    assign st_pay   = rd_pay;
  end

  logic             out_valid_q, out_valid_d;
  logic [PAY_W-1:0] out_pay_q, out_pay_d;

  always_comb begin
    out_valid_d = st_valid;
    out_pay_d   = st_valid ? st_pay : out_pay_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pay_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pay_q   <= out_pay_d;
    end
  end

  assign bus.rd_valid = out_valid_q;
  assign bus.rd_data  = out_pay_q[DATA_WIDTH-1:0];
`ifdef FPGA_PROTO_RAM_PARITY_EN
  assign bus.rd_perr  = out_pay_q[PAY_W-1 -: MASK_WIDTH];
`endif

endmodule

// File: tb/tb_fpga_proto_ram_model_sdp.sv
// -----------------------------------------------------------------------------
// tb_fpga_proto_ram_model_sdp
// Directed bench for two instances sharing clk/rst_n:
//   dut_a : defaults (512 words, latency 1, WRITE_FIRST, clear on reset)
//   dut_b : 256 words, latency 2, READ_FIRST, no clear on reset
// Inputs change on the falling edge; outputs are checked on the falling edge.
// FPGA_PROTO_RAM_PARITY_EN adds a parity-injection step.
// -----------------------------------------------------------------------------
module tb_fpga_proto_ram_model_sdp;

  localparam int AW = 9;
  localparam int DW = 72;
  localparam int MW = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic init_req_a, init_req_b, init_busy_a, init_busy_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpga_proto_ram_model_sdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus_a ();
  fpga_proto_ram_model_sdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus_b ();

  fpga_proto_ram_model_sdp dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req_a),
    .init_busy(init_busy_a),
    .bus      (bus_a)
  );

  fpga_proto_ram_model_sdp #(
    .ADDR_WIDTH   (AW),
    .RAM_DEPTH    (256),
    .DATA_WIDTH   (DW),
    .MASK_WIDTH   (MW),
    .READ_LATENCY (2),
    .COLL_MODE    ("READ_FIRST"),
    .INIT_ON_RESET(0)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req_b),
    .init_busy(init_busy_b),
    .bus      (bus_b)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a();
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d; bus_a.wr_mask = m;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus_b.wr_en = 1'b1; bus_b.wr_addr = a; bus_b.wr_data = d; bus_b.wr_mask = m;
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    bus_a.rd_en = 1'b1; bus_a.rd_addr = a;
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    bus_b.rd_en = 1'b1; bus_b.rd_addr = a;
  endtask

  // Counts falling edges with init_busy_a high, starting at the next one;
  // bounded so a stuck sweep still ends (and reads as the wrong length).
  task automatic count_busy_a(output int n);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (init_busy_a) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    int bad;

    rst_n      = 1'b0;
    init_req_a = 1'b0;
    init_req_b = 1'b0;
    idle_a(); idle_b();
    bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_mask = '0; bus_a.rd_addr = '0;
    bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_mask = '0; bus_b.rd_addr = '0;
`ifdef FPGA_PROTO_RAM_PARITY_EN
    bus_a.perr_inject = '0;
    bus_b.perr_inject = '0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy_a",  80'(init_busy_a),    80'(1));
    check("rst_busy_b",  80'(init_busy_b),    80'(0));
    check("rst_valid_a", 80'(bus_a.rd_valid), 80'(0));
    check("rst_data_a",  80'(bus_a.rd_data),  80'(0));
    check("rst_valid_b", 80'(bus_b.rd_valid), 80'(0));
    check("rst_data_b",  80'(bus_b.rd_data),  80'(0));

    // Sweep after release lasts exactly RAM_DEPTH cycles
    rst_n = 1'b1;
    count_busy_a(n);
    check("sweep_len", 80'(n), 80'(512));

    // Top address reads zero, one cycle latency, single-cycle valid
    rd_a(9'h1FF); step();
    check("rd_1ff_valid", 80'(bus_a.rd_valid), 80'(1));
    check("rd_1ff_data",  80'(bus_a.rd_data),  80'(0));
    idle_a(); step();
    check("valid_pulse",  80'(bus_a.rd_valid), 80'(0));

    // Lane mask: only lane 0 cleared; zero mask writes nothing
    wr_a(9'd5, {9{8'hFF}}, 9'h1FF); step();
    wr_a(9'd5, '0, 9'h001); step();
    wr_a(9'd5, {9{8'h12}}, 9'h000); step();
    idle_a(); rd_a(9'd5); step();
    check("mask_valid", 80'(bus_a.rd_valid), 80'(1));
    check("mask_data",  80'(bus_a.rd_data),  80'(72'hFF_FFFF_FFFF_FFFF_FF00));
    idle_a(); step();
    check("hold_valid", 80'(bus_a.rd_valid), 80'(0));
    check("hold_data",  80'(bus_a.rd_data),  80'(72'hFF_FFFF_FFFF_FFFF_FF00));

    // WRITE_FIRST collisions: full mask, then partial mask (lanes 4..7)
    wr_a(9'd7, {9{8'h11}}, 9'h1FF); step();
    wr_a(9'd7, {9{8'hAA}}, 9'h1FF); rd_a(9'd7); step();
    check("wf_full", 80'(bus_a.rd_data), 80'({9{8'hAA}}));
    wr_a(9'd7, {9{8'h55}}, 9'h0F0); rd_a(9'd7); step();
    check("wf_part", 80'(bus_a.rd_data), 80'(72'hAA_5555_5555_AAAA_AAAA));
    idle_a(); rd_a(9'd7); step();
    check("wf_stored", 80'(bus_a.rd_data), 80'(72'hAA_5555_5555_AAAA_AAAA));
    idle_a();

`ifdef FPGA_PROTO_RAM_PARITY_EN
    // Injected parity on lane 2 shows up as rd_perr with unchanged data
    bus_a.perr_inject = 9'h004;
    wr_a(9'd9, 72'h01_2345_6789_ABCD_EF01, 9'h1FF); step();
    bus_a.perr_inject = '0;
    idle_a(); rd_a(9'd9); step();
    check("perr_bits", 80'(bus_a.rd_perr), 80'(9'h004));
    check("perr_data", 80'(bus_a.rd_data), 80'(72'h01_2345_6789_ABCD_EF01));
    idle_a();
`endif

    // B: READ_FIRST collision with two-cycle latency
    wr_b(9'd7, {9{8'h11}}, 9'h1FF); step();
    wr_b(9'd7, {9{8'hAA}}, 9'h1FF); rd_b(9'd7); step();
    idle_b();
    check("rf_lat_v0", 80'(bus_b.rd_valid), 80'(0));
    step();
    check("rf_valid", 80'(bus_b.rd_valid), 80'(1));
    check("rf_data",  80'(bus_b.rd_data),  80'({9{8'h11}}));
    rd_b(9'd7); step(); idle_b(); step();
    check("rf_after", 80'(bus_b.rd_data), 80'({9{8'hAA}}));

    // B: back-to-back reads, in order, full throughput
    wr_b(9'd1, {9{8'h01}}, 9'h1FF); step();
    wr_b(9'd2, {9{8'h02}}, 9'h1FF); step();
    wr_b(9'd3, {9{8'h03}}, 9'h1FF); step();
    idle_b();
    rd_b(9'd1); step();
    check("b2b_v0", 80'(bus_b.rd_valid), 80'(0));
    rd_b(9'd2); step();
    check("b2b_v1", 80'(bus_b.rd_valid), 80'(1));
    check("b2b_d1", 80'(bus_b.rd_data),  80'({9{8'h01}}));
    rd_b(9'd3); step();
    check("b2b_v2", 80'(bus_b.rd_valid), 80'(1));
    check("b2b_d2", 80'(bus_b.rd_data),  80'({9{8'h02}}));
    idle_b(); step();
    check("b2b_v3", 80'(bus_b.rd_valid), 80'(1));
    check("b2b_d3", 80'(bus_b.rd_data),  80'({9{8'h03}}));
    step();
    check("b2b_end_v", 80'(bus_b.rd_valid), 80'(0));
    check("b2b_end_d", 80'(bus_b.rd_data),  80'({9{8'h03}}));

    // B: out-of-range write dropped (no alias onto 0), read returns zero
    wr_b(9'h000, {9{8'h22}}, 9'h1FF); step();
    wr_b(9'h100, {9{8'h33}}, 9'h1FF); step();
    idle_b(); rd_b(9'h000); step();
    rd_b(9'h100); step();
    check("oor_alias", 80'(bus_b.rd_data), 80'({9{8'h22}}));
    idle_b(); step();
    check("oor_valid", 80'(bus_b.rd_valid), 80'(1));
    check("oor_data",  80'(bus_b.rd_data),  80'(0));

    // A: init_req with a same-cycle read; reads held off during the sweep
    init_req_a = 1'b1; rd_a(9'd5); step();
    init_req_a = 1'b0;
    check("ireq_busy",  80'(init_busy_a),    80'(1));
    check("ireq_valid", 80'(bus_a.rd_valid), 80'(0));
    bad = 0;
    n   = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!init_busy_a) break;
      n++;
      if (bus_a.rd_valid) bad++;
    end
    check("resweep_len",   80'(n),   80'(512));
    check("sweep_noval",   80'(bad), 80'(0));
    step();
    check("clr5_valid", 80'(bus_a.rd_valid), 80'(1));
    check("clr5_data",  80'(bus_a.rd_data),  80'(0));
    rd_a(9'd7); step();
    check("clr7_data",  80'(bus_a.rd_data),  80'(0));
    idle_a();

    // Asynchronous reset mid-sweep (A) and mid-read (B)
    init_req_a = 1'b1; rd_b(9'd2); step();
    init_req_a = 1'b0; idle_b(); step();
    check("pre_rst_v_b", 80'(bus_b.rd_valid), 80'(1));
    check("pre_rst_d_b", 80'(bus_b.rd_data),  80'({9{8'h02}}));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_b", 80'(bus_b.rd_valid), 80'(0));
    check("arst_data_b",  80'(bus_b.rd_data),  80'(0));
    check("arst_busy_a",  80'(init_busy_a),    80'(1));
    check("arst_busy_b",  80'(init_busy_b),    80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_busy_a(n);
    check("restart_len", 80'(n), 80'(512));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
